// File: rtl/vout_timing_gen_if.sv
// ============================================================================
// Module   : vout_if
// Purpose  : Control inputs and raster outputs of the output timing generator.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface vout_if #(
    parameter int XW = 12,
    parameter int YW = 11
);
    logic          en_i;
    logic [1:0]    pat_sel_i;
    logic          hs_o;
    logic          vs_o;
    logic          de_o;
    logic [23:0]   data_o;
    logic [XW-1:0] x_o;
    logic [YW-1:0] y_o;
    logic          sof_o;
    logic          busy_o;

    modport master (
        output en_i, pat_sel_i,
        input  hs_o, vs_o, de_o, data_o, x_o, y_o, sof_o, busy_o
    );

    modport slave (
        input  en_i, pat_sel_i,
        output hs_o, vs_o, de_o, data_o, x_o, y_o, sof_o, busy_o
    );
endinterface

`default_nettype wire

// File: rtl/vout_timing_gen.sv
// ============================================================================
// Module   : vout_timing_gen
// Purpose  : Raster timing generator (hs/vs/de) with test-pattern pixel stream.
// Revision : 1.0
// ============================================================================
`default_nettype none

module vout_timing_gen #(
    parameter int unsigned H_WIDTH  = 1920,
    parameter int unsigned H_FP     = 88,
    parameter int unsigned H_SYNC   = 44,
    parameter int unsigned H_TOTAL  = 2200,
    parameter int unsigned V_HEIGHT = 1080,
    parameter int unsigned V_FP     = 4,
    parameter int unsigned V_SYNC   = 5,
    parameter int unsigned V_TOTAL  = 1125,
    parameter bit          HS_POL   = 1'b1,
    parameter bit          VS_POL   = 1'b1,
    parameter int unsigned KH       = 30,
    parameter int unsigned KV       = 30
) (
    input  logic   vout_clk_i,
    input  logic   rst_n,
    vout_if.slave  bus
);

    localparam int XW  = $clog2(H_TOTAL);
    localparam int YW  = $clog2(V_TOTAL);
    localparam int HCW = XW + 1;
    localparam int VCW = YW + 1;
    localparam int AW  = $clog2(H_WIDTH + 8) + 1;
    localparam int SHW = $clog2(KH + 1);
    localparam int SVW = $clog2(KV + 1);

    localparam logic [HCW-1:0] C_H_ACT   = HCW'(H_WIDTH);
    localparam logic [HCW-1:0] C_HS_BEG  = HCW'(H_WIDTH + H_FP);
    localparam logic [HCW-1:0] C_HS_END  = HCW'(H_WIDTH + H_FP + H_SYNC);
    localparam logic [HCW-1:0] C_H_LAST  = HCW'(H_TOTAL - 1);
    localparam logic [VCW-1:0] C_V_ACT   = VCW'(V_HEIGHT);
    localparam logic [VCW-1:0] C_VS_BEG  = VCW'(V_HEIGHT + V_FP);
    localparam logic [VCW-1:0] C_VS_END  = VCW'(V_HEIGHT + V_FP + V_SYNC);
    localparam logic [VCW-1:0] C_V_LAST  = VCW'(V_TOTAL - 1);
    localparam logic [AW-1:0]  C_ACC_W   = AW'(H_WIDTH);
    localparam logic [AW-1:0]  C_ACC_INC = AW'(8);
    localparam logic [SHW-1:0] C_KH_LAST = SHW'(KH - 1);
    localparam logic [SVW-1:0] C_KV_LAST = SVW'(KV - 1);
    localparam logic [23:0]    C_WHITE   = 24'hFFFFFF;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [XW-1:0] hc_q, hc_d;
    logic [YW-1:0] vc_q, vc_d;
    logic [1:0]    pat_q;
    logic [AW-1:0] acc_q, acc_d;
    logic [2:0]    bar_q, bar_d;
    logic [SHW-1:0] hsub_q, hsub_d;
    logic [SVW-1:0] vsub_q, vsub_d;
    logic          hpar_q, hpar_d;
    logic          vpar_q, vpar_d;

    logic          hs_q, vs_q, de_q, sof_q, busy_q;
    logic [23:0]   data_q;
    logic [XW-1:0] x_q;
    logic [YW-1:0] y_q;

    logic [HCW-1:0] w_hcx;
    logic [VCW-1:0] w_vcx;
    logic           w_run, w_h_last, w_v_last, w_origin;
    logic           w_de, w_hs, w_vs;
    logic [1:0]     w_pat;
    logic [AW-1:0]  w_acc_sum;
    logic [23:0]    w_rgb;

    assign w_hcx    = {1'b0, hc_q};
    assign w_vcx    = {1'b0, vc_q};
    assign w_run    = (state_q != S_IDLE);
    assign w_h_last = (w_hcx == C_H_LAST);
    assign w_v_last = (w_vcx == C_V_LAST);
    assign w_origin = (hc_q == '0) && (vc_q == '0);
    assign w_de     = (w_hcx < C_H_ACT) && (w_vcx < C_V_ACT);
    assign w_hs     = (w_hcx >= C_HS_BEG) && (w_hcx < C_HS_END);
    assign w_vs     = (w_vcx >= C_VS_BEG) && (w_vcx < C_VS_END);
    // The first pixel of a frame takes the live selection; the rest of the frame uses the latched copy.
    assign w_pat    = w_origin ? bus.pat_sel_i : pat_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.en_i) state_d = S_RUN;
            S_RUN:   if (!bus.en_i) state_d = S_DRAIN;
            S_DRAIN: begin
                if (bus.en_i)                   state_d = S_RUN;
                else if (w_h_last && w_v_last)  state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        hc_d = hc_q;
        vc_d = vc_q;
        if (!w_run) begin
            hc_d = '0;
            vc_d = '0;
        end else if (w_h_last) begin
            hc_d = '0;
            vc_d = w_v_last ? '0 : vc_q + 1'b1;
        end else begin
            hc_d = hc_q + 1'b1;
        end
    end

    // Bar index tracks floor(hc*8/H_WIDTH) by accumulating 8 per pixel modulo H_WIDTH.
    assign w_acc_sum = acc_q + C_ACC_INC;

    always_comb begin
        acc_d = acc_q;
        bar_d = bar_q;
        if (!w_run || w_h_last) begin
            acc_d = '0;
            bar_d = '0;
        end else if (w_acc_sum >= C_ACC_W) begin
            acc_d = w_acc_sum - C_ACC_W;
            bar_d = (bar_q == 3'd7) ? bar_q : bar_q + 3'd1;
        end else begin
            acc_d = w_acc_sum;
        end
    end

    always_comb begin
        hsub_d = hsub_q;
        hpar_d = hpar_q;
        vsub_d = vsub_q;
        vpar_d = vpar_q;
        if (!w_run || w_h_last) begin
            hsub_d = '0;
            hpar_d = 1'b0;
        end else if (hsub_q == C_KH_LAST) begin
            hsub_d = '0;
            hpar_d = ~hpar_q;
        end else begin
            hsub_d = hsub_q + 1'b1;
        end
        if (!w_run || (w_h_last && w_v_last)) begin
            vsub_d = '0;
            vpar_d = 1'b0;
        end else if (w_h_last) begin
            if (vsub_q == C_KV_LAST) begin
                vsub_d = '0;
                vpar_d = ~vpar_q;
            end else begin
                vsub_d = vsub_q + 1'b1;
            end
        end
    end

    always_comb begin
        w_rgb = 24'h000000;
        case (w_pat)
            2'd1: w_rgb = C_WHITE;
            2'd2: begin
                case (bar_q)
                    3'd0:    w_rgb = 24'hFFFFFF;
                    3'd1:    w_rgb = 24'hFFFF00;
                    3'd2:    w_rgb = 24'h00FFFF;
                    3'd3:    w_rgb = 24'h00FF00;
                    3'd4:    w_rgb = 24'hFF00FF;
                    3'd5:    w_rgb = 24'hFF0000;
                    3'd6:    w_rgb = 24'h0000FF;
                    default: w_rgb = 24'h000000;
                endcase
            end
            2'd3:    w_rgb = (hpar_q ^ vpar_q) ? C_WHITE : 24'h000000;
            default: w_rgb = 24'h000000;
        endcase
    end

    always_ff @(posedge vout_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            hc_q    <= '0;
            vc_q    <= '0;
            pat_q   <= '0;
            acc_q   <= '0;
            bar_q   <= '0;
            hsub_q  <= '0;
            vsub_q  <= '0;
            hpar_q  <= 1'b0;
            vpar_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hc_q    <= hc_d;
            vc_q    <= vc_d;
            if (w_origin) pat_q <= bus.pat_sel_i;
            acc_q   <= acc_d;
            bar_q   <= bar_d;
            hsub_q  <= hsub_d;
            vsub_q  <= vsub_d;
            hpar_q  <= hpar_d;
            vpar_q  <= vpar_d;
        end
    end

    // Output stage: decode of the current counters, presented one cycle later together.
    always_ff @(posedge vout_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            hs_q   <= ~HS_POL;
            vs_q   <= ~VS_POL;
            de_q   <= 1'b0;
            data_q <= '0;
            x_q    <= '0;
            y_q    <= '0;
            sof_q  <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            hs_q   <= (w_run && w_hs) ? HS_POL : ~HS_POL;
            vs_q   <= (w_run && w_vs) ? VS_POL : ~VS_POL;
            de_q   <= w_run && w_de;
            data_q <= (w_run && w_de) ? w_rgb : 24'h000000;
            x_q    <= w_run ? hc_q : '0;
            y_q    <= w_run ? vc_q : '0;
            sof_q  <= w_run && w_origin;
            busy_q <= w_run;
        end
    end

    assign bus.hs_o   = hs_q;
    assign bus.vs_o   = vs_q;
    assign bus.de_o   = de_q;
    assign bus.data_o = data_q;
    assign bus.x_o    = x_q;
    assign bus.y_o    = y_q;
    assign bus.sof_o  = sof_q;
    assign bus.busy_o = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_vout_timing_gen.sv
// ============================================================================
// Module   : tb_vout_timing_gen
// Purpose  : Scoreboard bench for vout_timing_gen on a small raster geometry.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_vout_timing_gen;

    localparam int HW = 8, HFP = 2, HSW = 2, HT = 16;
    localparam int VH = 4, VFP = 1, VSW = 1, VT = 8;
    localparam int KH = 2, KV = 2;
    localparam bit HP = 1'b1, VP = 1'b1;
    localparam int NPIX = HT * VT;

    typedef struct {
        bit          busy;
        bit          hs;
        bit          vs;
        bit          de;
        bit          sof;
        logic [23:0] data;
        int          x;
        int          y;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vout_if #(.XW(4), .YW(3)) vif ();

    vout_timing_gen #(
        .H_WIDTH(HW), .H_FP(HFP), .H_SYNC(HSW), .H_TOTAL(HT),
        .V_HEIGHT(VH), .V_FP(VFP), .V_SYNC(VSW), .V_TOTAL(VT),
        .HS_POL(HP), .VS_POL(VP), .KH(KH), .KV(KV)
    ) dut (
        .vout_clk_i (clk),
        .rst_n      (rst_n),
        .bus        (vif)
    );

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;
    bit   chk_on = 1'b0;

    // Reference raster: a running flag, a linear pixel index and a pending stop request.
    bit        m_act = 1'b0;
    bit        m_drain = 1'b0;
    int        m_p = 0;
    logic [1:0] m_pat = 2'd0;

    function automatic logic [23:0] pix_rgb(int x, int y, logic [1:0] pat);
        int bar;
        if (!(x < HW && y < VH)) return 24'h0;
        case (pat)
            2'd1: return 24'hFFFFFF;
            2'd2: begin
                bar = (x * 8) / HW;
                case (bar)
                    0: return 24'hFFFFFF;
                    1: return 24'hFFFF00;
                    2: return 24'h00FFFF;
                    3: return 24'h00FF00;
                    4: return 24'hFF00FF;
                    5: return 24'hFF0000;
                    6: return 24'h0000FF;
                    default: return 24'h000000;
                endcase
            end
            2'd3: return ((((x / KH) ^ (y / KV)) & 1) == 1) ? 24'hFFFFFF : 24'h000000;
            default: return 24'h0;
        endcase
    endfunction

    function automatic exp_t idle_rec();
        exp_t r;
        r.busy = 1'b0; r.hs = !HP; r.vs = !VP; r.de = 1'b0; r.sof = 1'b0;
        r.data = 24'h0; r.x = 0; r.y = 0;
        return r;
    endfunction

    task automatic model_step(input bit en, input logic [1:0] pat);
        exp_t r;
        int x, y;
        if (m_act) begin
            x = m_p % HT;
            y = m_p / HT;
            if (m_p == 0) m_pat = pat;
            r.busy = 1'b1;
            r.de   = (x < HW) && (y < VH);
            r.hs   = (x >= HW + HFP && x < HW + HFP + HSW) ? HP : !HP;
            r.vs   = (y >= VH + VFP && y < VH + VFP + VSW) ? VP : !VP;
            r.sof  = (m_p == 0);
            r.x    = x;
            r.y    = y;
            r.data = pix_rgb(x, y, m_pat);
            if (m_drain && !en && m_p == NPIX - 1) m_act = 1'b0;
            else m_drain = !en;
            m_p = (m_p + 1) % NPIX;
        end else begin
            r = idle_rec();
            if (en) begin
                m_act = 1'b1;
                m_p = 0;
                m_drain = 1'b0;
            end
        end
        q.push_back(r);
    endtask

    task automatic apply(input bit en, input logic [1:0] pat);
        vif.en_i = en;
        vif.pat_sel_i = pat;
        model_step(en, pat);
    endtask

    task automatic drive(input bit en, input logic [1:0] pat);
        @(negedge clk);
        apply(en, pat);
    endtask

    task automatic check_reset(input string name);
        checks++;
        if (vif.hs_o !== !HP || vif.vs_o !== !VP || vif.de_o !== 1'b0 || vif.sof_o !== 1'b0 ||
            vif.busy_o !== 1'b0 || vif.data_o !== 24'h0 || vif.x_o !== 4'd0 || vif.y_o !== 3'd0) begin
            failures++;
            $display("FAIL %s: got hs=%b vs=%b de=%b sof=%b busy=%b data=%h x=%0d y=%0d, required inactive/zero",
                     name, vif.hs_o, vif.vs_o, vif.de_o, vif.sof_o, vif.busy_o, vif.data_o, vif.x_o, vif.y_o);
        end
    endtask

    // Run until the next pixel emitted by the reference is at linear index tgt.
    task automatic run_to(input int tgt, input logic [1:0] pat);
        for (int i = 0; i < 2 * NPIX; i++) begin
            if (m_act && m_p == tgt) break;
            drive(1'b1, pat);
        end
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (chk_on) begin
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL scoreboard_empty t=%0t: DUT output with no expected entry", $time);
            end else begin
                e = q.pop_front();
                if (vif.busy_o !== e.busy || vif.hs_o !== e.hs || vif.vs_o !== e.vs ||
                    vif.de_o !== e.de || vif.sof_o !== e.sof || vif.data_o !== e.data ||
                    int'(vif.x_o) != e.x || int'(vif.y_o) != e.y) begin
                    failures++;
                    $display("FAIL pixel t=%0t: got busy=%b hs=%b vs=%b de=%b sof=%b data=%h x=%0d y=%0d, required busy=%b hs=%b vs=%b de=%b sof=%b data=%h x=%0d y=%0d",
                             $time, vif.busy_o, vif.hs_o, vif.vs_o, vif.de_o, vif.sof_o, vif.data_o,
                             vif.x_o, vif.y_o, e.busy, e.hs, e.vs, e.de, e.sof, e.data, e.x, e.y);
                end
            end
        end
    end

    initial begin
        bit cur_en;
        vif.en_i = 1'b0;
        vif.pat_sel_i = 2'd0;
        #3;
        check_reset("reset_state");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk_on = 1'b1;
        apply(1'b0, 2'd1);
        repeat (4) drive(1'b0, 2'd1);

        // White frame, then three frames with the selection changing every cycle.
        for (int i = 0; i < NPIX + 2; i++) drive(1'b1, 2'd1);
        for (int i = 0; i < 3 * NPIX; i++) drive(1'b1, 2'($urandom_range(0, 3)));

        // Checker frame.
        run_to(0, 2'd3);
        for (int i = 0; i < NPIX; i++) drive(1'b1, 2'd3);

        // Selection change mid-frame only takes effect on the next frame.
        run_to(0, 2'd1);
        run_to(2 * HT, 2'd1);
        for (int i = 0; i < 2 * NPIX; i++) drive(1'b1, 2'd2);

        // Drop enable at y=1, x=3; frame completes, then idle, then restart.
        run_to(1 * HT + 3, 2'd1);
        for (int i = 0; i < 2 * NPIX; i++) drive(1'b0, 2'd1);
        for (int i = 0; i < NPIX + 4; i++) drive(1'b1, 2'd3);

        // Asynchronous reset in the middle of a frame with enable held high.
        run_to(3 * HT + 5, 2'd2);
        @(negedge clk);
        chk_on = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_reset("reset_midframe");
        repeat (2) @(negedge clk);
        check_reset("reset_held");
        rst_n = 1'b1;
        m_act = 1'b0; m_drain = 1'b0; m_p = 0;
        chk_on = 1'b1;
        apply(1'b1, 2'd2);
        for (int i = 0; i < NPIX + 4; i++) drive(1'b1, 2'd2);

        // Random enable toggling including drops near frame boundaries.
        cur_en = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 99) < 2) cur_en = !cur_en;
            drive(cur_en, 2'($urandom_range(0, 3)));
        end

        for (int i = 0; i < 3 * NPIX; i++) begin
            if (!m_act) break;
            drive(1'b0, 2'd0);
        end
        repeat (4) drive(1'b0, 2'd0);
        @(posedge clk);
        #2;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
